// File: rtl/full_adder_4bit.sv
// Registered WIDTH-bit unsigned adder built from a ripple chain of 1-bit full-adder cells.
// Optional signed-overflow output enabled by defining FULL_ADDER_4BIT_SIGNED_OVF_EN.

module full_adder_4bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module full_adder_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH:0]   Sum,
    output logic             out_valid
`ifdef FULL_ADDER_4BIT_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH:0]   sum_d, sum_q;
    logic             valid_d, valid_q;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_4bit_cell u_cell (
            .a_i (A[i]),
            .b_i (B[i]),
            .c_i (c[i]),
            .s_o (s[i]),
            .c_o (c[i+1])
        );
    end

    // Sum holds on idle cycles so operand activity cannot disturb it.
    always_comb begin
        sum_d   = sum_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d = {c[WIDTH], s};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign Sum       = sum_q;
    assign out_valid = valid_q;

`ifdef FULL_ADDER_4BIT_SIGNED_OVF_EN
    logic ovf_d, ovf_q;

    // Carries into and out of the sign bit disagree exactly on signed overflow.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_4bit.sv
// Scoreboard bench for full_adder_4bit: driver pushes expected results, monitor pops and compares.
// Checks signed overflow too when FULL_ADDER_4BIT_SIGNED_OVF_EN is defined.

module tb_full_adder_4bit;

    localparam int W = 4;

    typedef struct {
        int unsigned sum;
        bit          ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         in_valid;
    logic [W:0]   Sum;
    logic         out_valid;
    logic         ovf_w;

    bit   clk_en;
    bit   exp_v;
    exp_t exp_q[$];
    exp_t last_exp;
    int   tests;
    int   failed;

    full_adder_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .in_valid  (in_valid),
        .Sum       (Sum),
        .out_valid (out_valid)
`ifdef FULL_ADDER_4BIT_SIGNED_OVF_EN
        ,
        .ovf       (ovf_w)
`endif
    );

`ifndef FULL_ADDER_4BIT_SIGNED_OVF_EN
    assign ovf_w = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on the operands.
    function automatic exp_t model(input int a, input int b, input int ci);
        exp_t e;
        int   sa, sb, ss;
        e.sum = (a + b + ci) % (1 << (W + 1));
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        ss = sa + sb + ci;
`ifdef FULL_ADDER_4BIT_SIGNED_OVF_EN
        e.ovf = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic issue(input int a, input int b, input int ci, input bit v);
        @(posedge clk);
        #1;
        A        = W'(a);
        B        = W'(b);
        cin      = ci[0];
        in_valid = v;
        if (v) exp_q.push_back(model(a, b, ci));
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("async_rst_sum", int'(Sum), 0);
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_ovf", int'(ovf_w), 0);
        exp_q.delete();
        last_exp.sum = 0;
        last_exp.ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(posedge clk) exp_v = in_valid && !rst;

    // Monitor: mid-cycle sampling, pops one expected result per presented output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_sum", int'(Sum), 0);
                check("rst_valid", int'(out_valid), 0);
            end else begin
                check("out_valid", int'(out_valid), int'(exp_v));
                if (exp_v) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL scoreboard_empty: got output Sum=%0d expected none", Sum);
                    end else begin
                        e = exp_q.pop_front();
                        check("sum", int'(Sum), int'(e.sum));
                        check("ovf", int'(ovf_w), int'(e.ovf));
                        last_exp = e;
                    end
                end else begin
                    check("hold_sum", int'(Sum), int'(last_exp.sum));
                    check("hold_ovf", int'(ovf_w), int'(last_exp.ovf));
                end
            end
        end
    end

    initial begin
        tests        = 0;
        failed       = 0;
        last_exp.sum = 0;
        last_exp.ovf = 1'b0;
        rst      = 1'b1;
        A        = '0;
        B        = '0;
        cin      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("init_rst_sum", int'(Sum), 0);
        check("init_rst_valid", int'(out_valid), 0);
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, 0, 0, 0);
        issue(0, 0, 0, 0);

        issue(0, 0, 0, 1);
        issue(5, 5, 0, 1);
        issue(15, 15, 0, 1);
        issue(15, 0, 1, 1);
        issue(15, 15, 1, 1);
        issue(7, 1, 0, 1);
        issue(8, 8, 0, 1);
        issue(8, 15, 1, 1);

        issue(5, 5, 0, 1);
        for (int i = 0; i < 3; i++) issue($urandom, $urandom, $urandom_range(0, 1), 0);

        issue(3, 4, 0, 1);
        issue(8, 8, 0, 1);
        issue(1, 14, 0, 1);
        issue(2, 2, 0, 0);
        mid_reset();
        issue(0, 0, 0, 0);

        issue(9, 9, 1, 1);
        mid_reset();
        issue(0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
                  $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
        end
        issue(0, 0, 0, 0);
        issue(0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
